sprite_mover: RTL

SPRITE_MOVER -- requirements
Module: sprite_mover

---
 rtl/sprite_mover.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/sprite_mover.sv
// sprite_mover: moves a sprite's top-left position under command control and
// renders or erases the sprite by streaming pixels from an external ROM to a
// framebuffer write port.
//
// Optional feature: define SPRITE_MOVER_WRAP_EN to make out-of-range moves
// wrap around the legal position range. Without it they clamp at the limit.
//
// Ports
//   clk        system clock, rising edge
//   reset_n    synchronous active-low reset
//   cmd_valid  command offered
//   cmd_op     0 NOP, 1 LEFT, 2 RIGHT, 3 UP, 4 DOWN, 5 DRAW, 6 CLEAR, 7 HOME
//   cmd_ready  high only in IDLE
//   pos_x/y    current sprite top-left position
//   at_edge    position sits on a screen limit
//   rom_addr   sprite ROM address (ROM answers one cycle later)
//   rom_data   sprite ROM pixel colour
//   x_out/y_out/colour/plot  framebuffer pixel write
//   done       one-cycle pulse on command completion
//
// state | meaning
// IDLE  | waiting for a command, cmd_ready high
// SCAN  | issuing one ROM address per cycle, row-major
// FLUSH | last pixel of the scan on the write port
// DONE  | completion pulse, back to IDLE next
module sprite_mover #(
  parameter int SCREEN_W = 160,
  parameter int SCREEN_H = 120,
  parameter int SPR_W    = 15,
  parameter int SPR_H    = 10,
  parameter int STEP     = 1,
  parameter int HOME_X   = 80,
  parameter int HOME_Y   = 60,
  parameter int COLOUR_W = 24,
  parameter int XW       = 8,
  parameter int YW       = 7,
  parameter int AW       = 8
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                cmd_valid,
  input  logic [2:0]          cmd_op,
  output logic                cmd_ready,
  output logic [XW-1:0]       pos_x,
  output logic [YW-1:0]       pos_y,
  output logic                at_edge,
  output logic [AW-1:0]       rom_addr,
  input  logic [COLOUR_W-1:0] rom_data,
  output logic [XW-1:0]       x_out,
  output logic [YW-1:0]       y_out,
  output logic [COLOUR_W-1:0] colour,
  output logic                plot,
  output logic                done
);

  localparam int MAXX = SCREEN_W - SPR_W;
  localparam int MAXY = SCREEN_H - SPR_H;
  localparam int CW   = (SPR_W > 1) ? $clog2(SPR_W) : 1;
  localparam int RW   = (SPR_H > 1) ? $clog2(SPR_H) : 1;

  localparam logic [2:0] OP_LEFT  = 3'd1;
  localparam logic [2:0] OP_RIGHT = 3'd2;
  localparam logic [2:0] OP_UP    = 3'd3;
  localparam logic [2:0] OP_DOWN  = 3'd4;
  localparam logic [2:0] OP_DRAW  = 3'd5;
  localparam logic [2:0] OP_CLEAR = 3'd6;
  localparam logic [2:0] OP_HOME  = 3'd7;

  typedef enum logic [1:0] {IDLE, SCAN, FLUSH, DONE} state_t;

  state_t          state;
  logic [CW-1:0]   col;
  logic [RW-1:0]   row;
  logic [XW-1:0]   snap_x;
  logic [YW-1:0]   snap_y;
  logic            draw_q;

  // One coordinate step; dec selects the decreasing direction.
  function automatic int next_pos(input int cur, input logic dec, input int lim);
    int n;
    if (dec) begin
      if (cur >= STEP) n = cur - STEP;
`ifdef SPRITE_MOVER_WRAP_EN
      else n = cur + lim + 1 - STEP;
`else
      else n = 0;
`endif
    end else begin
      if (cur + STEP <= lim) n = cur + STEP;
`ifdef SPRITE_MOVER_WRAP_EN
      else n = cur + STEP - (lim + 1);
`else
      else n = lim;
`endif
    end
    return n;
  endfunction

  assign cmd_ready = (state == IDLE);
  assign done      = (state == DONE);
  assign at_edge   = (pos_x == '0) || (pos_x == XW'(MAXX)) ||
                     (pos_y == '0) || (pos_y == YW'(MAXY));
  // ROM data arrives in the same cycle the registered plot for its address
  // goes high, so colour is selected combinationally from registered state.
  assign colour    = (plot && draw_q) ? rom_data : '0;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state    <= IDLE;
      pos_x    <= XW'(HOME_X);
      pos_y    <= YW'(HOME_Y);
      plot     <= 1'b0;
      x_out    <= '0;
      y_out    <= '0;
      rom_addr <= '0;
      col      <= '0;
      row      <= '0;
      snap_x   <= '0;
      snap_y   <= '0;
      draw_q   <= 1'b0;
    end else begin
      plot <= 1'b0;
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            state <= DONE;
            case (cmd_op)
              OP_LEFT:  pos_x <= XW'(next_pos(int'(pos_x), 1'b1, MAXX));
              OP_RIGHT: pos_x <= XW'(next_pos(int'(pos_x), 1'b0, MAXX));
              OP_UP:    pos_y <= YW'(next_pos(int'(pos_y), 1'b1, MAXY));
              OP_DOWN:  pos_y <= YW'(next_pos(int'(pos_y), 1'b0, MAXY));
              OP_HOME: begin
                pos_x <= XW'(HOME_X);
                pos_y <= YW'(HOME_Y);
              end
              OP_DRAW, OP_CLEAR: begin
                snap_x   <= pos_x;
                snap_y   <= pos_y;
                col      <= '0;
                row      <= '0;
                rom_addr <= '0;
                draw_q   <= (cmd_op == OP_DRAW);
                state    <= SCAN;
              end
              default: ;
            endcase
          end
        end
        SCAN: begin
          plot  <= 1'b1;
          x_out <= snap_x + XW'(col);
          y_out <= snap_y + YW'(row);
          if (col == CW'(SPR_W - 1)) begin
            col <= '0;
            if (row == RW'(SPR_H - 1)) begin
              state <= FLUSH;
            end else begin
              row      <= row + RW'(1);
              rom_addr <= rom_addr + AW'(1);
            end
          end else begin
            col      <= col + CW'(1);
            rom_addr <= rom_addr + AW'(1);
          end
        end
        FLUSH:   state <= DONE;
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
